// File: rtl/pixel_ctrl_pkg.sv
// Shared types and defaults for the pixel frame sequencer.
// Build option GRAY_COUNT_EN (see pixel_conv_counter) selects the Gray-coded ramp count.
package pixel_ctrl_pkg;

  localparam int unsigned DEF_ERASE_CYCLES  = 5;
  localparam int unsigned DEF_EXPOSE_CYCLES = 255;
  localparam int unsigned DEF_DATA_W        = 8;
  localparam int unsigned DEF_N_PIX         = 4;

  // Frame phases, in the order a frame visits them.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ERASE    = 3'd1,
    S_EXPOSE   = 3'd2,
    S_CONVERT  = 3'd3,
    S_TURN     = 3'd4,
    S_READ_SET = 3'd5,
    S_READ_OUT = 3'd6
  } state_e;

  // Gray code of a zero-extended binary value; callers truncate to their width.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/pixel_conv_counter.sv
// Conversion ramp counter: clear/enable binary count with registered code output.
// GRAY_COUNT_EN defined: o_code is the Gray code of the count; undefined: plain binary.
module pixel_conv_counter
  import pixel_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_en,
  output logic [DATA_W-1:0] o_code,
  output logic              o_tc
);

  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] w_next_count;
  logic [DATA_W-1:0] w_next_code;

  // Next count: clear wins over enable, otherwise hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_next_count = r_count;
    if (i_clr) begin
      w_next_count = '0;
    end else if (i_en) begin
      w_next_count = r_count + DATA_W'(1);
    end
`ifdef GRAY_COUNT_EN
    w_next_code = DATA_W'(bin2gray(32'(w_next_count)));
`else
    w_next_code = w_next_count;
`endif
  end

  // Count and its encoded form are both registered so o_code is glitch-free on the buses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      o_code  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_count <= w_next_count;
      o_code  <= w_next_code;
    end
  end

  assign o_tc = (r_count == {DATA_W{1'b1}});

endmodule

// File: rtl/pixel_frame_ctrl.sv
// Frame sequencer for the pixel array: erase, expose, ramp conversion, then
// one-at-a-time readout of the latched pixel codes over a valid/ready stream.
// GRAY_COUNT_EN (in pixel_conv_counter) switches cnt_out to Gray code.
module pixel_frame_ctrl
  import pixel_ctrl_pkg::*;
#(
  parameter int ERASE_CYCLES  = DEF_ERASE_CYCLES,
  parameter int EXPOSE_CYCLES = DEF_EXPOSE_CYCLES,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int N_PIX         = DEF_N_PIX,
  localparam int IDX_W        = (N_PIX > 1) ? $clog2(N_PIX) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    erase,
  output logic                    expose,
  output logic                    convert,
  output logic [N_PIX-1:0]        read,
  output logic [DATA_W-1:0]       cnt_out,
  output logic                    cnt_oe,
  input  logic [N_PIX*DATA_W-1:0] pix_in,
  output logic [DATA_W-1:0]       out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int PH_MAX = (ERASE_CYCLES > EXPOSE_CYCLES) ? ERASE_CYCLES : EXPOSE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [PH_W-1:0]  r_phase;
  logic [PH_W-1:0]  w_next_phase;
  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] w_next_k;
  logic [N_PIX-1:0] w_next_read;
  logic             w_hs;
  logic             w_last_pix;
  logic             w_tc;
  logic             w_cnt_clr;
  logic             w_cnt_en;

  assign w_hs       = out_valid & out_ready;
  assign w_last_pix = (r_k == IDX_W'(N_PIX - 1));

  // The counter sits at zero outside CONVERT, so the first CONVERT cycle shows count 0.
  assign w_cnt_clr = (w_next_state != S_CONVERT);
  assign w_cnt_en  = (r_state == S_CONVERT);

  pixel_conv_counter #(
    .DATA_W (DATA_W)
  ) u_conv_counter (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .o_code (cnt_out),
    .o_tc   (w_tc)
  );

  // Next-state, phase-counter and pixel-index logic.
  always_comb begin
    w_next_state = r_state;
    w_next_phase = r_phase;
    w_next_k     = r_k;
    case (r_state)
      S_IDLE: begin
        w_next_phase = '0;
        w_next_k     = '0;
        if (start) w_next_state = S_ERASE;
      end
      S_ERASE: begin
        if (r_phase == PH_W'(ERASE_CYCLES - 1)) begin
          w_next_state = S_EXPOSE;
          w_next_phase = '0;
        end else begin
          w_next_phase = r_phase + PH_W'(1);
        end
      end
      S_EXPOSE: begin
        if (r_phase == PH_W'(EXPOSE_CYCLES - 1)) begin
          w_next_state = S_CONVERT;
          w_next_phase = '0;
        end else begin
          w_next_phase = r_phase + PH_W'(1);
        end
      end
      S_CONVERT:  if (w_tc) w_next_state = S_TURN;
      S_TURN:     w_next_state = S_READ_SET;
      S_READ_SET: w_next_state = S_READ_OUT;
      S_READ_OUT: begin
        if (w_hs) begin
          if (w_last_pix) begin
            w_next_state = S_IDLE;
            w_next_k     = '0;
          end else begin
            w_next_state = S_READ_SET;
            w_next_k     = r_k + IDX_W'(1);
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // One-hot read strobe for the pixel the next cycle will address; zero outside readout.
  always_comb begin
    w_next_read = '0;
    if (w_next_state == S_READ_SET || w_next_state == S_READ_OUT) begin
      w_next_read[w_next_k] = 1'b1;
    end
  end

  // State, counters and strobes; strobes are decoded from the next state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_phase    <= '0;
      r_k        <= '0;
      erase      <= 1'b0;
      expose     <= 1'b0;
      convert    <= 1'b0;
      cnt_oe     <= 1'b0;
      read       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_phase    <= w_next_phase;
      r_k        <= w_next_k;
      erase      <= (w_next_state == S_ERASE);
      expose     <= (w_next_state == S_EXPOSE);
      convert    <= (w_next_state == S_CONVERT);
      cnt_oe     <= (w_next_state == S_CONVERT);
      read       <= w_next_read;
      busy       <= (w_next_state != S_IDLE);
      frame_done <= (r_state == S_READ_OUT) && w_hs && w_last_pix;
    end
  end

  // Output stream: capture pixel k on entry to READ_OUT, hold until the consumer accepts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data  <= '0;
      out_idx   <= '0;
      out_valid <= 1'b0;
    end else if (r_state == S_READ_SET) begin
      out_data  <= pix_in[int'(r_k) * DATA_W +: DATA_W];
      out_idx   <= r_k;
      out_valid <= 1'b1;
    end else if (w_hs) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// Directed bench for pixel_frame_ctrl: a DATA_W=4 instance for frame timing,
// start/reset behaviour and the ramp count, and a DATA_W=8 instance for pixel data
// and backpressure. Expected ramp codes follow GRAY_COUNT_EN when it is defined.
module tb_pixel_frame_ctrl;

  localparam int NP   = 4;
  localparam int DW_A = 4;
  localparam int DW_B = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic              start_a, ready_a;
  logic [NP*DW_A-1:0] pix_a;
  logic              erase_a, expose_a, convert_a, cnt_oe_a, valid_a, busy_a, done_a;
  logic [NP-1:0]     read_a;
  logic [DW_A-1:0]   cnt_a, data_a;
  logic [1:0]        idx_a;

  logic              start_b, ready_b;
  logic [NP*DW_B-1:0] pix_b;
  logic              erase_b, expose_b, convert_b, cnt_oe_b, valid_b, busy_b, done_b;
  logic [NP-1:0]     read_b;
  logic [DW_B-1:0]   cnt_b, data_b;
  logic [1:0]        idx_b;

  pixel_frame_ctrl #(.ERASE_CYCLES(2), .EXPOSE_CYCLES(3), .DATA_W(DW_A), .N_PIX(NP)) dut_a (
    .clk(clk), .reset(rst), .start(start_a), .erase(erase_a), .expose(expose_a),
    .convert(convert_a), .read(read_a), .cnt_out(cnt_a), .cnt_oe(cnt_oe_a), .pix_in(pix_a),
    .out_data(data_a), .out_idx(idx_a), .out_valid(valid_a), .out_ready(ready_a),
    .busy(busy_a), .frame_done(done_a)
  );

  pixel_frame_ctrl #(.ERASE_CYCLES(2), .EXPOSE_CYCLES(3), .DATA_W(DW_B), .N_PIX(NP)) dut_b (
    .clk(clk), .reset(rst), .start(start_b), .erase(erase_b), .expose(expose_b),
    .convert(convert_b), .read(read_b), .cnt_out(cnt_b), .cnt_oe(cnt_oe_b), .pix_in(pix_b),
    .out_data(data_b), .out_idx(idx_b), .out_valid(valid_b), .out_ready(ready_b),
    .busy(busy_b), .frame_done(done_b)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected ramp code for count c on the 4-bit instance.
  function automatic logic [3:0] code4(input int c);
`ifdef GRAY_COUNT_EN
    return 4'(c ^ (c >> 1));
`else
    return 4'(c);
`endif
  endfunction

  // Frame statistics gathered by run_a.
  int         m_erase, m_expose, m_conv, m_turn, m_done_at, m_first_erase;
  int         m_overlap, m_cnt_bad;
  int         m_valid [NP];
  int         m_idx_log [$];
  logic [3:0] m_cnt_log [16];

  // Runs one frame on dut_a; caller raises start_a just before the call.
  task automatic run_a(input bit pulse_start);
    bit pulsed_exp = 1'b0;
    bit pulsed_ro  = 1'b0;
    bit clr_start  = 1'b0;
    m_erase = 0; m_expose = 0; m_conv = 0; m_turn = 0; m_done_at = -1;
    m_first_erase = 0; m_overlap = 0; m_cnt_bad = 0;
    for (int i = 0; i < NP; i++) m_valid[i] = 0;
    m_idx_log.delete();
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (n == 1) begin
        m_first_erase = int'(erase_a);
        start_a = 1'b0;
      end
      if (clr_start) begin
        start_a   = 1'b0;
        clr_start = 1'b0;
      end
      if (erase_a)  m_erase++;
      if (expose_a) m_expose++;
      if (convert_a) begin
        if (m_conv < 16) begin
          m_cnt_log[m_conv] = cnt_a;
          if (cnt_a !== code4(m_conv)) m_cnt_bad++;
        end
        m_conv++;
      end
      if (busy_a && !erase_a && !expose_a && !convert_a && read_a == '0) m_turn++;
      if (cnt_oe_a && read_a != '0) m_overlap++;
      if (valid_a) begin
        m_valid[idx_a]++;
        m_idx_log.push_back(int'(idx_a));
      end
      if (pulse_start && expose_a && !pulsed_exp) begin
        start_a = 1'b1; pulsed_exp = 1'b1; clr_start = 1'b1;
      end
      if (pulse_start && valid_a && !pulsed_ro) begin
        start_a = 1'b1; pulsed_ro = 1'b1; clr_start = 1'b1;
      end
      if (done_a) begin
        m_done_at = n - 1;
        break;
      end
    end
  endtask

  task automatic check_frame_a(input string pfx);
    check({pfx, "_erase_cycles"},  m_erase, 2);
    check({pfx, "_expose_cycles"}, m_expose, 3);
    check({pfx, "_convert_cycles"}, m_conv, 16);
    check({pfx, "_turn_cycles"},   m_turn, 1);
    check({pfx, "_done_at"},       m_done_at, 2 + 3 + 16 + 1 + 8);
    check({pfx, "_idx_count"},     m_idx_log.size(), 4);
    for (int i = 0; i < NP; i++) begin
      check({pfx, "_valid_per_idx"}, m_valid[i], 1);
      if (i < m_idx_log.size()) check({pfx, "_idx_order"}, m_idx_log[i], i);
    end
    check({pfx, "_oe_read_overlap"}, m_overlap, 0);
    check({pfx, "_cnt_seq_bad"},     m_cnt_bad, 0);
  endtask

  int        bad_cnt, quiet_bad, found7;
  int        rd1, stable_bad, stalls, ov_b, done_at_b;
  logic [7:0] data_log [$];

  initial begin
    rst = 1'b1; start_a = 1'b1; start_b = 1'b0; ready_a = 1'b1; ready_b = 1'b1;
    pix_a = 16'h0000;
    pix_b = {8'hA3, 8'h11, 8'hFF, 8'h00};
    // Reset with start held high: every output stays zero.
    repeat (3) tick();
    check("rst_erase",   erase_a, 0);
    check("rst_strobes", {expose_a, convert_a, cnt_oe_a, busy_a, done_a, valid_a}, 0);
    check("rst_read",    read_a, 0);
    check("rst_cnt_out", cnt_a, 0);
    check("rst_data",    {data_a, idx_a}, 0);

    // Release reset with start still high: erase rises on the next edge; first full frame.
    rst = 1'b0;
    run_a(1'b0);
    check("first_erase", m_first_erase, 1);
    check_frame_a("f1");
    check("f1_cnt_log2", m_cnt_log[2], code4(2));
    check("f1_cnt_log4", m_cnt_log[4], code4(4));
    check("f1_cnt_log15", m_cnt_log[15], code4(15));

    // start pulses during EXPOSE and READ_OUT are ignored; frame length unchanged.
    tick();
    start_a = 1'b1;
    run_a(1'b1);
    check_frame_a("f2");
    repeat (3) tick();
    check("f2_no_relaunch", {busy_a, erase_a}, 0);

    // Reset mid-CONVERT at count 7.
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    found7 = 0;
    for (int n = 0; n < 100; n++) begin
      tick();
      if (convert_a && cnt_a == code4(7)) begin
        found7 = 1;
        break;
      end
    end
    check("mid_conv_found7", found7, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_convert", {convert_a, cnt_oe_a}, 0);
    check("mid_rst_cnt_out", cnt_a, 0);
    check("mid_rst_busy",    {busy_a, read_a, valid_a}, 0);
    tick();
    rst = 1'b0;
    quiet_bad = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (valid_a || done_a || busy_a) quiet_bad++;
    end
    check("post_rst_quiet", quiet_bad, 0);
    start_a = 1'b1;
    run_a(1'b0);
    check_frame_a("f3");

    // Data path and backpressure on the 8-bit instance: 3 stall cycles on pixel 1.
    start_b = 1'b1;
    rd1 = 0; stable_bad = 0; stalls = 0; ov_b = 0; done_at_b = -1;
    data_log.delete();
    for (int n = 1; n <= 600; n++) begin
      tick();
      if (n == 1) start_b = 1'b0;
      if (cnt_oe_b && read_b != '0) ov_b++;
      if (read_b[1]) rd1++;
      if (valid_b) begin
        if (idx_b == 2'd1) begin
          if (data_b !== 8'hFF) stable_bad++;
          if (stalls < 3) begin
            ready_b = 1'b0;
            stalls++;
          end else begin
            ready_b = 1'b1;
          end
        end else begin
          ready_b = 1'b1;
        end
        if (ready_b) data_log.push_back(data_b);
      end
      if (done_b) begin
        done_at_b = n - 1;
        break;
      end
    end
    ready_b = 1'b1;
    check("b_data_count", data_log.size(), 4);
    if (data_log.size() == 4) begin
      check("b_data0", data_log[0], 8'h00);
      check("b_data1", data_log[1], 8'hFF);
      check("b_data2", data_log[2], 8'h11);
      check("b_data3", data_log[3], 8'hA3);
    end
    check("b_stall_stable", stable_bad, 0);
    check("b_read1_cycles", rd1, 5);
    check("b_done_at",      done_at_b, 2 + 3 + 256 + 1 + 8 + 3);
    check("b_oe_read_overlap", ov_b, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_frame_ctrl.md
# pixel_frame_ctrl

Sequencer for the four-pixel sensor array. It runs each frame through erase, expose, convert and read:
- drives the array's erase, expose and read strobes;
- drives the shared conversion count onto the pixel data buses during conversion;
- reads back the four latched pixel codes one at a time over a valid/ready stream.

It sits between the array and the downstream readout logic.

## Interface
Parameters:
- ERASE_CYCLES, 5, cycles erase is held high
- EXPOSE_CYCLES, 255, cycles expose is held high
- DATA_W, 8, pixel code width; conversion lasts 2^DATA_W cycles
- N_PIX, 4, pixels sequenced; read strobe and bus count

Ports:
- clk  in  1  clock, single clock domain
- reset  in  1  asynchronous, active-high reset
- start  in  1  frame request; sampled in IDLE only
- erase  out  1  pixel erase strobe
- expose  out  1  pixel expose strobe
- convert  out  1  ramp-run indicator; high for all of CONVERT
- read  out  N_PIX  one-hot pixel read strobes
- cnt_out  out  DATA_W  conversion count for the pixel buses
- cnt_oe  out  1  enables the cnt_out drivers onto all pixel buses
- pix_in  in  N_PIX*DATA_W  sampled pixel buses; pixel k occupies bits [k*DATA_W +: DATA_W]
- out_data  out  DATA_W  pixel code
- out_idx  out  $clog2(N_PIX)  pixel index of out_data
- out_valid  out  1  out_data/out_idx valid
- out_ready  in  1  consumer accepts
- busy  out  1  high in any state except IDLE
- frame_done  out  1  one-cycle pulse after the last pixel is accepted

## Operation
- States: IDLE → ERASE → EXPOSE → CONVERT → TURN → READ_SET → READ_OUT, then back to READ_SET or to IDLE.
- IDLE: all strobes low. start=1 → ERASE. The phase counter loads 0.
- ERASE: erase=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: expose=1 for exactly EXPOSE_CYCLES cycles, then CONVERT.
- CONVERT: convert=1 and cnt_oe=1 for 2^DATA_W cycles.
  - cnt_out steps through count values 0 .. 2^DATA_W-1, one per cycle, starting at 0 in the first CONVERT cycle.
  - Then TURN.
- TURN: one cycle. cnt_oe=0, convert=0, read=0. This is the bus turnaround; cnt_oe and read are never high together.
- READ_SET: read[k]=1 for one settle cycle, then READ_OUT. k starts at 0.
- READ_OUT:
  - read[k] stays high.
  - On entry, out_data is registered from pix_in slice k, out_idx=k and out_valid=1.
  - out_data/out_idx hold while out_valid=1 and out_ready=0.
  - When out_valid && out_ready: read[k] and out_valid drop on the next edge.
  - If k<N_PIX-1: k increments and the block goes to READ_SET.
  - Otherwise: frame_done=1 for one cycle and the block goes to IDLE.
- out_ready already high on entry to READ_OUT: the handshake completes in that first cycle.
- start is ignored while busy=1. start held high in IDLE launches back-to-back frames, with a single IDLE cycle between them.
- Reset asserted in any state:
  - immediate return to IDLE;
  - every output goes to 0, with cnt_out=0, read=0 and out_valid=0;
  - counters clear;
  - no frame_done is produced and no partial-frame output follows.

## Timing
- All outputs are registered. Reset value of every output is 0.
- start sampled at edge t → erase=1 from t+1.
- Frame length from start to the last READ_OUT with zero backpressure: ERASE_CYCLES + EXPOSE_CYCLES + 2^DATA_W + 1 + 2·N_PIX cycles.
- Each stall cycle on out_ready adds one cycle to the frame.
- Each pixel: read[k] is high for 1 + (cycles in READ_OUT) cycles. out_valid rises one cycle after read[k].

## Configuration
- GRAY_COUNT_EN defined: cnt_out carries the Gray code of the count (c ^ (c>>1)). Consecutive values differ in exactly one bit.
- GRAY_COUNT_EN undefined: cnt_out is plain binary.
- In both modes out_data passes pixel codes through unchanged; decoding happens downstream.

## Structure
- Package pixel_ctrl_pkg holds:
  - the state enum type;
  - default constants for ERASE_CYCLES, EXPOSE_CYCLES and DATA_W;
  - a function bin2gray.
- Sub-module pixel_conv_counter:
  - DATA_W-bit counter with clear and enable;
  - binary/Gray output selected by GRAY_COUNT_EN;
  - terminal-count flag.

## Test plan
- Reset with start=1 held: all outputs 0. After release, erase rises on the next edge.
- Full frame with ERASE_CYCLES=2, EXPOSE_CYCLES=3, DATA_W=4 and out_ready=1:
  - exactly 2 erase, 3 expose and 16 convert cycles, then 1 TURN cycle;
  - out_idx 0,1,2,3 each valid for one cycle;
  - frame_done exactly at cycle 2+3+16+1+8.
- pix_in = {8'hA3, 8'h11, 8'hFF, 8'h00} (pixel 3 → pixel 0), with out_ready low for 3 cycles on pixel 1:
  - out_data sequence 00, FF, 11, A3;
  - pixel-1 data stable during the stall;
  - read[1] high for 5 cycles.
- Pulse start during EXPOSE and during READ_OUT: no effect, and the frame length is unchanged.
- Assert reset mid-CONVERT with cnt_out=7:
  - cnt_oe, convert and cnt_out go to 0 immediately;
  - no out_valid and no frame_done follow;
  - the next start runs a clean frame.
- Count sequence with DATA_W=4:
  - with GRAY_COUNT_EN: cnt_out is 0,1,3,2,6,… with a single-bit change each cycle;
  - without it: 0..15.
  - In both modes, a check confirms cnt_oe and any read bit are never high together.
